// File: rtl/arbitro_rr_param.sv
`default_nettype none
// arbitro_rr_param: round-robin arbiter that drains NUM_IN show-ahead FIFOs into NUM_OUT
// destination FIFOs chosen by each word's top DEST_W bits, with per-output word counters.
module arbitro_rr_param #(
   parameter int NUM_IN     = 4,
   parameter int NUM_OUT    = 4,
   parameter int DATA_W     = 12,
   parameter int DEST_W     = 2,
   parameter int STALL_MODE = 1,
   parameter int CNT_W      = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_IN-1:0]        empty,
   input  logic [NUM_IN*DATA_W-1:0] fifo_out,
   input  logic [NUM_OUT-1:0]       almost_full,
   output logic [NUM_IN-1:0]        pop,
   output logic [NUM_OUT-1:0]       push,
   output logic [DATA_W-1:0]        data_out,
   output logic [NUM_OUT*CNT_W-1:0] cnt_out,
   output logic                     idle
);

   localparam int IDX_W = $clog2(NUM_IN);

   typedef enum logic [0:0] {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [IDX_W-1:0]  rr;
   logic [IDX_W-1:0]  rr_nxt;
   logic [IDX_W-1:0]  grant_idx;
   logic              grant_vld;
   logic [DATA_W-1:0] grant_word;
   logic [DEST_W-1:0] grant_dest;
   logic [NUM_IN-1:0] eligible;
   logic [DATA_W-1:0] word [NUM_IN];
   logic [CNT_W-1:0]  cnt  [NUM_OUT];

   for (genvar i = 0; i < NUM_IN; i++) begin : g_elig
      assign word[i] = fifo_out[i*DATA_W +: DATA_W];
      if (STALL_MODE != 0) begin : g_per_dest
         assign eligible[i] = ~empty[i] & ~almost_full[word[i][DATA_W-1 -: DEST_W]];
      end else begin : g_global
         assign eligible[i] = ~empty[i] & ~(|almost_full);
      end
   end

   for (genvar d = 0; d < NUM_OUT; d++) begin : g_cnt
      assign cnt_out[d*CNT_W +: CNT_W] = cnt[d];
   end

   always_comb begin
      state_nxt  = state;
      pop        = '0;
      grant_vld  = 1'b0;
      grant_idx  = '0;
      grant_word = '0;
      grant_dest = '0;
      rr_nxt     = rr;

      if (state == S_INIT) begin
         state_nxt = S_RUN;
      end

      // Two descending passes, last hit wins: the lowest eligible index at or above rr
      // beats everything, otherwise the lowest eligible index below rr (the wrap).
      if ((state == S_RUN) && !reset) begin
         for (int i = NUM_IN-1; i >= 0; i--) begin
            if (eligible[i] && (IDX_W'(i) < rr)) begin
               grant_vld = 1'b1;
               grant_idx = IDX_W'(i);
            end
         end
         for (int i = NUM_IN-1; i >= 0; i--) begin
            if (eligible[i] && (IDX_W'(i) >= rr)) begin
               grant_vld = 1'b1;
               grant_idx = IDX_W'(i);
            end
         end
      end

      if (grant_vld) begin
         pop[grant_idx] = 1'b1;
         grant_word     = word[grant_idx];
         grant_dest     = grant_word[DATA_W-1 -: DEST_W];
         rr_nxt         = (grant_idx == IDX_W'(NUM_IN-1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_INIT;
         rr       <= '0;
         push     <= '0;
         data_out <= '0;
         idle     <= 1'b1;
         for (int d = 0; d < NUM_OUT; d++) begin
            cnt[d] <= '0;
         end
      end else begin
         state <= state_nxt;
         idle  <= (state == S_RUN) && !grant_vld && (push == '0);
         push  <= '0;
         if (grant_vld) begin
            rr               <= rr_nxt;
            push[grant_dest] <= 1'b1;
            data_out         <= grant_word;
            cnt[grant_dest]  <= cnt[grant_dest] + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_arbitro_rr_param.sv
`default_nettype none
// tb_arbitro_rr_param: three arbiter instances (per-destination stall, global stall,
// 4-bit counters) driven with shared inputs and checked against a reference model.
module tb_arbitro_rr_param;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  empty;
   logic [47:0] fifo_out;
   logic [3:0]  almost_full;

   logic [3:0]  pop_a  [3];
   logic [3:0]  push_a [3];
   logic [11:0] data_a [3];
   logic        idle_a [3];
   logic [31:0] cnt_a  [2];
   logic [15:0] cnt_w;

   always #5 clk = ~clk;

   arbitro_rr_param #(.NUM_IN(4), .NUM_OUT(4), .DATA_W(12), .DEST_W(2), .STALL_MODE(1), .CNT_W(8)) dut_p (
      .clk(clk), .reset(reset), .empty(empty), .fifo_out(fifo_out), .almost_full(almost_full),
      .pop(pop_a[0]), .push(push_a[0]), .data_out(data_a[0]), .cnt_out(cnt_a[0]), .idle(idle_a[0]));

   arbitro_rr_param #(.NUM_IN(4), .NUM_OUT(4), .DATA_W(12), .DEST_W(2), .STALL_MODE(0), .CNT_W(8)) dut_g (
      .clk(clk), .reset(reset), .empty(empty), .fifo_out(fifo_out), .almost_full(almost_full),
      .pop(pop_a[1]), .push(push_a[1]), .data_out(data_a[1]), .cnt_out(cnt_a[1]), .idle(idle_a[1]));

   arbitro_rr_param #(.NUM_IN(4), .NUM_OUT(4), .DATA_W(12), .DEST_W(2), .STALL_MODE(1), .CNT_W(4)) dut_w (
      .clk(clk), .reset(reset), .empty(empty), .fifo_out(fifo_out), .almost_full(almost_full),
      .pop(pop_a[2]), .push(push_a[2]), .data_out(data_a[2]), .cnt_out(cnt_w), .idle(idle_a[2]));

   typedef struct packed {
      logic [31:0] due;
      logic [3:0]  push;
      logic [11:0] data;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc   = 0;

   int          m_rr   [3];
   bit          m_run  [3];
   bit          m_idle [3];
   bit          m_pnow [3];
   logic [11:0] m_data [3];
   int          m_cnt  [3][4];

   logic [11:0] stream_w [4];
   logic [11:0] h_a, h_b, h_c;
   logic        seen0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: actual=%0h expected=%0h at t=%0t", tag, act, exp_v, $time);
      end
   endtask

   task automatic sb_put(input int i, input exp_t it);
      case (i)
         0:       q0.push_back(it);
         1:       q1.push_back(it);
         default: q2.push_back(it);
      endcase
   endtask

   task automatic sb_take(input int i, output bit got, output exp_t it);
      got = 1'b0;
      it  = '0;
      case (i)
         0: if (q0.size() > 0 && q0[0].due == cyc) begin it = q0.pop_front(); got = 1'b1; end
         1: if (q1.size() > 0 && q1[0].due == cyc) begin it = q1.pop_front(); got = 1'b1; end
         default: if (q2.size() > 0 && q2[0].due == cyc) begin it = q2.pop_front(); got = 1'b1; end
      endcase
   endtask

   function automatic logic [31:0] dut_cnt(input int i, input int d);
      if (i == 2) return {28'd0, cnt_w[d*4 +: 4]};
      return {24'd0, cnt_a[i][d*8 +: 8]};
   endfunction

   // Compare the registered outputs right after an edge against the scoreboard/model.
   task automatic check_regs(input int i);
      bit   got;
      exp_t it;
      int   mask;
      mask = (i == 2) ? 'hF : 'hFF;
      sb_take(i, got, it);
      if (got) begin
         check_val($sformatf("push%0d", i), push_a[i], it.push);
         check_val($sformatf("data%0d", i), data_a[i], it.data);
      end else begin
         check_val($sformatf("nopush%0d", i), push_a[i], 0);
         check_val($sformatf("hold%0d", i), data_a[i], m_data[i]);
      end
      check_val($sformatf("idle%0d", i), idle_a[i], m_idle[i]);
      for (int d = 0; d < 4; d++) begin
         check_val($sformatf("cnt%0d_%0d", i, d), dut_cnt(i, d), m_cnt[i][d] & mask);
      end
   endtask

   // Reference arbitration for the inputs just driven; also advances the model state.
   task automatic model_step(input int i, input logic rst, input logic [3:0] e,
                             input logic [47:0] f, input logic [3:0] af);
      int          g;
      int          mode;
      logic [1:0]  idx;
      logic [1:0]  dst;
      logic        blk;
      logic [11:0] h [4];
      exp_t        it;
      mode = (i == 1) ? 0 : 1;
      g    = -1;
      for (int k = 0; k < 4; k++) h[k] = f[k*12 +: 12];
      if (!rst && m_run[i]) begin
         for (int k = 0; k < 4; k++) begin
            idx = 2'(m_rr[i] + k);
            dst = h[idx][11:10];
            blk = (mode == 1) ? af[dst] : (af != 4'd0);
            if (g < 0 && !e[idx] && !blk) g = int'(idx);
         end
      end
      check_val($sformatf("pop%0d", i), pop_a[i], (g >= 0) ? (32'd1 << g) : 32'd0);
      if (rst) begin
         m_rr[i] = 0; m_run[i] = 1'b0; m_idle[i] = 1'b1; m_pnow[i] = 1'b0; m_data[i] = '0;
         for (int d = 0; d < 4; d++) m_cnt[i][d] = 0;
      end else begin
         m_idle[i] = m_run[i] && (g < 0) && !m_pnow[i];
         m_run[i]  = 1'b1;
         m_pnow[i] = 1'b0;
         if (g >= 0) begin
            idx  = 2'(g);
            dst  = h[idx][11:10];
            m_rr[i] = (g + 1) % 4;
            m_cnt[i][dst]++;
            m_data[i] = h[idx];
            m_pnow[i] = 1'b1;
            it.due  = 32'(cyc + 1);
            it.push = 4'b0001 << dst;
            it.data = h[idx];
            sb_put(i, it);
         end
      end
   endtask

   task automatic tick(input logic rst, input logic [3:0] e, input logic [47:0] f, input logic [3:0] af);
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 3; i++) check_regs(i);
      reset       = rst;
      empty       = e;
      fifo_out    = f;
      almost_full = af;
      #1;
      for (int i = 0; i < 3; i++) model_step(i, rst, e, f, af);
   endtask

   initial begin
      reset = 1'b1; empty = 4'hF; fifo_out = '0; almost_full = '0;
      for (int i = 0; i < 3; i++) begin
         m_rr[i] = 0; m_run[i] = 1'b0; m_idle[i] = 1'b1; m_pnow[i] = 1'b0; m_data[i] = '0;
         for (int d = 0; d < 4; d++) m_cnt[i][d] = 0;
      end
      stream_w[0] = 12'b001010010110;
      stream_w[1] = 12'b010000100101;
      stream_w[2] = 12'b100000100100;
      stream_w[3] = 12'b111010100101;

      tick(1'b1, 4'hF, '0, 4'h0);
      tick(1'b1, 4'hF, '0, 4'h0);
      tick(1'b0, 4'hF, '0, 4'h0);
      tick(1'b0, 4'hF, '0, 4'h0);

      // Single input streaming, one word per destination.
      for (int k = 0; k < 4; k++) tick(1'b0, 4'b1110, {36'd0, stream_w[k]}, 4'h0);
      tick(1'b0, 4'hF, '0, 4'h0);
      check_val("cnt_single", cnt_a[0], 32'h01010101);
      tick(1'b0, 4'hF, '0, 4'h0);

      // Round-robin fairness, every word to destination 0.
      tick(1'b1, 4'hF, '0, 4'h0);
      tick(1'b0, 4'hF, '0, 4'h0);
      for (int k = 0; k < 8; k++) begin
         tick(1'b0, 4'h0, {12'h044, 12'h033, 12'h022, 12'h011}, 4'h0);
         check_val("rr_order", pop_a[0], 4'b0001 << (k % 4));
      end
      tick(1'b0, 4'hF, '0, 4'h0);
      check_val("cnt_fair", cnt_a[0][7:0], 8);

      // Stall behaviour: input 0 heads to the almost-full destination 2.
      h_a = 12'b101010100101;
      h_b = 12'b010000000001;
      tick(1'b1, 4'hF, '0, 4'h0);
      tick(1'b0, 4'hF, '0, 4'h0);
      for (int k = 0; k < 6; k++) begin
         tick(1'b0, 4'b1100, {24'd0, h_b, h_a}, 4'b0100);
         check_val("stall_dest", pop_a[0], 4'b0010);
         check_val("stall_global", pop_a[1], 4'b0000);
      end
      seen0 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick(1'b0, 4'b1100, {24'd0, h_b, h_a}, 4'b0000);
         seen0 = seen0 | pop_a[0][0];
      end
      check_val("stall_release", seen0, 1);
      tick(1'b0, 4'b1100, {24'd0, h_b, h_a}, 4'b0100);
      h_c = 12'h155;
      tick(1'b0, 4'b0011, {h_c, h_c, 24'd0}, 4'b0000);
      tick(1'b0, 4'b0011, {h_c, h_c, 24'd0}, 4'b0000);
      tick(1'b0, 4'hF, '0, 4'h0);

      // Reset in the middle of continuous traffic.
      for (int k = 0; k < 3; k++) tick(1'b0, 4'h0, {12'hCDE, 12'h9AB, 12'h456, 12'h123}, 4'h0);
      tick(1'b1, 4'h0, {12'hCDE, 12'h9AB, 12'h456, 12'h123}, 4'h0);
      check_val("rst_pop", pop_a[0], 4'b0000);
      tick(1'b0, 4'h0, {12'hCDE, 12'h9AB, 12'h456, 12'h123}, 4'h0);
      check_val("init_pop", pop_a[0], 4'b0000);
      check_val("rst_cnt", cnt_a[0], 32'd0);
      check_val("rst_idle", idle_a[0], 1);
      tick(1'b0, 4'b1001, {12'hCDE, 12'h9AB, 12'h456, 12'h123}, 4'h0);
      check_val("first_grant", pop_a[0], 4'b0010);
      tick(1'b0, 4'hF, '0, 4'h0);

      // Counter wrap: 17 words to destination 3.
      tick(1'b1, 4'hF, '0, 4'h0);
      tick(1'b0, 4'hF, '0, 4'h0);
      for (int k = 0; k < 17; k++) tick(1'b0, 4'b0111, {12'hC05, 36'd0}, 4'h0);
      tick(1'b0, 4'hF, '0, 4'h0);
      check_val("wrap_cnt4", cnt_w[15:12], 1);
      check_val("wrap_cnt8", cnt_a[0][31:24], 17);
      tick(1'b0, 4'hF, '0, 4'h0);
      tick(1'b0, 4'hF, '0, 4'h0);

      check_val("sb_left", q0.size() + q1.size() + q2.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/arbitro_rr_param.md
Name: arbitro_rr_param

Overview:
- Parametrised successor to the single-input 4-output arbiter.
- Serves NUM_IN show-ahead input FIFOs round-robin and routes each popped word to one of NUM_OUT output FIFOs. The destination comes from the word's top bits.
- Backpressure is per destination when STALL_MODE=1: only words headed to an almost-full output wait. STALL_MODE=0 keeps the legacy global stall, where any almost_full halts all traffic.
- Sits between the input FIFO bank and the output FIFO bank; adds per-output word counters and an idle flag.

Parameters:
NUM_IN, 4, number of input FIFOs (2..8)
NUM_OUT, 4, number of output FIFOs (power of 2, 2..8)
DATA_W, 12, word width
DEST_W, 2, destination field width = log2(NUM_OUT); field is data[DATA_W-1 -: DEST_W]
STALL_MODE, 1, 0 = global stall on any almost_full; 1 = per-destination stall
CNT_W, 8, width of each per-output word counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
empty  input  NUM_IN  per-input FIFO empty flag
fifo_out  input  NUM_IN*DATA_W  head word of each input FIFO; input i at [i*DATA_W +: DATA_W]
almost_full  input  NUM_OUT  per-output FIFO almost-full flag
pop  output  NUM_IN  one-hot-or-zero pop strobe, combinational
push  output  NUM_OUT  one-hot-or-zero push strobe, registered
data_out  output  DATA_W  word accompanying push, registered
cnt_out  output  NUM_OUT*CNT_W  words pushed per output, registered
idle  output  1  high when nothing popped and nothing pending

Behaviour:
- Reset:
  - push=0, data_out=0, cnt_out=0, idle=1.
  - Round-robin pointer rr=0; state=INIT.
  - pop is forced 0 while reset=1.
- States:
  - INIT: one cycle after reset deasserts; pop=0, no push. Then goes to RUN.
  - RUN: normal arbitration.
  - reset in any state returns to INIT on the next edge.
- Eligibility (RUN, comb): input i is eligible iff empty[i]=0 and it is not blocked.
  - STALL_MODE=1: blocked iff almost_full[dest(fifo_out_i)]=1.
  - STALL_MODE=0: blocked iff any almost_full bit=1.
- Grant (comb):
  - First eligible input scanning rr, rr+1, …, NUM_IN-1, 0, …, rr-1 (wraps).
  - pop[g]=1 in the same cycle. At most one pop per cycle. No eligible input → pop=0.
- Pointer: on a grant to g, rr <= (g+1) mod NUM_IN. No grant → rr unchanged.
- Output stage, 1-cycle latency:
  - Edge after pop[g]: push[dest]=1 and data_out=fifo_out_g for exactly one cycle.
  - Otherwise push=0 and data_out holds its last value.
  - Back-to-back pops give a push every cycle.
- Counters:
  - cnt_out[d] increments on the edge where push[d] is asserted.
  - Wraps modulo 2^CNT_W, no saturation.
- idle: registered; 1 iff in RUN, no pop this cycle, and no push this cycle.
- Boundaries:
  - almost_full is sampled only at the grant decision. A word already granted is always pushed next cycle even if almost_full rises meanwhile. Output FIFO thresholds leave at least 1 free entry.
  - All inputs empty → no pop, rr held.
  - All eligible words blocked (STALL_MODE=1) → no pop; unblocked inputs behind a blocked one are still served.
  - reset asserted in the same cycle as a pop:
    - pop is suppressed, so no word is lost.
    - A registered push already on the outputs completes that cycle.
    - The counter for that push is cleared, since reset has priority.
  - Identical head words on two inputs are served in rr order, one per cycle.

Test Plan:
- Single input streaming:
  - Stimulus: NUM_IN=4, only input 0 non-empty; heads 12'b001010010110, 12'b010000100101, 12'b100000100100, 12'b111010100101 on consecutive cycles.
  - Response: pop[0] on 4 consecutive cycles; push=0001,0010,0100,1000 one cycle later, with matching data_out; cnt_out=1 each.
- Round-robin fairness:
  - Stimulus: all 4 inputs non-empty for 8 cycles, all to dest 0.
  - Response: pop order 0,1,2,3,0,1,2,3; cnt_out[0]=8.
- Per-destination stall:
  - Stimulus: STALL_MODE=1, almost_full[2]=1; input 0 head 12'b101010100101 (dest 2), input 1 head dest 1.
  - Response: input 0 never popped; input 1 popped every cycle; push[2] stays 0; after almost_full[2]=0, input 0 popped within NUM_IN cycles.
- Global stall:
  - Stimulus: STALL_MODE=0, same setup as the per-destination stall case.
  - Response: pop=0 while almost_full≠0; traffic resumes the cycle after it clears.
- Reset mid-stream:
  - Stimulus: reset=1 for 1 cycle during continuous traffic.
  - Response: pop=0 that cycle and during INIT; cnt_out=0, idle=1, rr=0 afterwards; first post-INIT grant goes to the lowest non-empty input.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 pushes to dest 3.
  - Response: cnt_out[3]=1.
